// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, fetch FSM states and default widths.
// Used by fetch_control, program_rom and the datapath.
package cpu_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 8;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_NAND  = 4'h7;
    localparam logic [3:0] OP_NOR   = 4'h8;
    localparam logic [3:0] OP_LOAD  = 4'h9;
    localparam logic [3:0] OP_STORE = 4'hA;
    localparam logic [3:0] OP_LAST_LEGAL = OP_STORE;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_EXEC    = 2'd2,
        ST_HALT    = 2'd3
    } fetch_state_t;

    function automatic logic isLegalOp(input logic [3:0] op);
        return op <= OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/fetch_control_if.sv
// ROM bus and datapath handshake between fetch_control (master) and its
// ROM / datapath neighbours (slave).
interface fetch_control_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
);
    logic [ADDR_W-1:0] addr_p;
    logic [DATA_W-1:0] out_prom;
    logic [3:0]        op;
    logic [3:0]        arg;
    logic              exec_valid;
    logic              exec_done;

    modport master (
        output addr_p, op, arg, exec_valid,
        input  out_prom, exec_done
    );

    modport slave (
        input  addr_p, op, arg, exec_valid,
        output out_prom, exec_done
    );
endinterface

// File: rtl/fetch_control_program_counter.sv
// Program counter: synchronous reset to PC_RESET, increments by one when
// enabled and wraps naturally at 2^ADDR_W.
module program_counter #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_control.sv
// Instruction fetch/sequencing FSM in front of program_rom. Optional feature:
// define HALT_ON_ILLEGAL_EN to stop in HALT on opcodes 0xB-0xF.
module fetch_control
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter int                DATA_W   = DATA_W_DEFAULT,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    fetch_control_if.master      bus,
    output logic [ADDR_W-1:0]    pc,
    output logic                 halted
);

    fetch_state_t      state_q;
    logic [DATA_W-1:0] ir_q;
    logic              execValid_q;
    logic              pcInc;

    // The ROM word belonging to pc arrives during CAPTURE, so pc advances there.
    assign pcInc = (state_q == ST_CAPTURE);

    program_counter #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (PC_RESET)
    ) u_pc (
        .clk   (clk),
        .rst   (rst),
        .inc_i (pcInc),
        .pc_o  (pc)
    );

`ifdef HALT_ON_ILLEGAL_EN
    logic halted_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            ir_q        <= '0;
            execValid_q <= 1'b0;
`ifdef HALT_ON_ILLEGAL_EN
            halted_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (run) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    ir_q <= bus.out_prom;
                    if (bus.out_prom[3:0] == OP_NOP) begin
                        state_q <= ST_FETCH;
                    end else if (isLegalOp(bus.out_prom[3:0])) begin
                        state_q     <= ST_EXEC;
                        execValid_q <= 1'b1;
                    end else begin
`ifdef HALT_ON_ILLEGAL_EN
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
`else
                        state_q <= ST_FETCH;
`endif
                    end
                end
                ST_EXEC: begin
                    if (bus.exec_done) begin
                        state_q     <= ST_FETCH;
                        execValid_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign bus.addr_p     = pc;
    assign bus.op         = ir_q[3:0];
    assign bus.arg        = ir_q[7:4];
    assign bus.exec_valid = execValid_q;

`ifdef HALT_ON_ILLEGAL_EN
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

endmodule
